// File: rtl/rgb_mux_pwm.sv
// Time-multiplexed PWM driver for common-anode LED channels with shadowed duties,
// slot blanking and a frame-start strobe. Optional gamma shaping: RGB_MUX_PWM_GAMMA_EN.
module rgb_mux_pwm #(
    parameter int CHANNELS         = 3,
    parameter int PWM_BITS         = 8,
    parameter int PRESCALE         = 256,
    parameter int PERIODS_PER_SLOT = 16,
    parameter int BLANK_CYCLES     = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [CHANNELS-1:0]                           en,
    input  logic [CHANNELS*PWM_BITS-1:0]                  duty,
    input  logic                                          load,
    output logic [CHANNELS-1:0]                           out,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] slot,
    output logic                                          frame_start
);

    localparam int SLOT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int PC_W   = (PERIODS_PER_SLOT > 1) ? $clog2(PERIODS_PER_SLOT) : 1;
    localparam int BL_W   = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic BLANK_EN = (BLANK_CYCLES > 0);
    // The reset cycle itself counts as the first blanked cycle of slot 0.
    localparam int BLANK_FIRST = (BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0;

    logic [PS_W-1:0]              presc_r;
    logic [PWM_BITS-1:0]          pwm_cnt_r;
    logic [PC_W-1:0]              period_cnt_r;
    logic [SLOT_W-1:0]            slot_r;
    logic [BL_W-1:0]              blank_cnt_r;
    logic                         fresh_r;
    logic                         frame_start_r;
    logic [CHANNELS-1:0]          pend_en_r;
    logic [CHANNELS*PWM_BITS-1:0] pend_duty_r;
    logic [CHANNELS-1:0]          act_en_r;
    logic [CHANNELS*PWM_BITS-1:0] act_duty_r;
    logic [CHANNELS-1:0]          out_r;

    logic                         tick_s;
    logic                         pb_s;
    logic                         sb_s;
    logic                         blanking_s;
    logic [CHANNELS*PWM_BITS-1:0] shaped_in_s;
    logic [CHANNELS*PWM_BITS-1:0] shaped_pend_s;
    logic [CHANNELS-1:0]          out_next_s;

    function automatic logic [PWM_BITS-1:0] shape(input logic [PWM_BITS-1:0] d);
`ifdef RGB_MUX_PWM_GAMMA_EN
        logic [2*PWM_BITS-1:0] prod;
        prod = (2*PWM_BITS)'(d) * (2*PWM_BITS)'(d);
        return prod[2*PWM_BITS-1:PWM_BITS];
`else
        return d;
`endif
    endfunction

    // Timing strobes and the duty mapping applied when shadow values go live.
    always_comb begin
        tick_s        = (presc_r == PS_W'(PRESCALE - 1));
        pb_s          = tick_s && (pwm_cnt_r == {PWM_BITS{1'b1}});
        sb_s          = pb_s && (period_cnt_r == PC_W'(PERIODS_PER_SLOT - 1));
        blanking_s    = (blank_cnt_r != {BL_W{1'b0}}) || (BLANK_EN && fresh_r);
        shaped_in_s   = {(CHANNELS*PWM_BITS){1'b0}};
        shaped_pend_s = {(CHANNELS*PWM_BITS){1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            shaped_in_s[k*PWM_BITS +: PWM_BITS]   = shape(duty[k*PWM_BITS +: PWM_BITS]);
            shaped_pend_s[k*PWM_BITS +: PWM_BITS] = shape(pend_duty_r[k*PWM_BITS +: PWM_BITS]);
        end
    end

    // Only the slot owner may conduct, so out can never be multi-hot.
    always_comb begin
        out_next_s = {CHANNELS{1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            out_next_s[k] = (slot_r == SLOT_W'(k)) && act_en_r[k] && !blanking_s &&
                            (act_duty_r[k*PWM_BITS +: PWM_BITS] > pwm_cnt_r);
        end
    end

    // Prescaler, PWM counter, period/slot sequencing, blanking and frame strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r       <= {PS_W{1'b0}};
            pwm_cnt_r     <= {PWM_BITS{1'b0}};
            period_cnt_r  <= {PC_W{1'b0}};
            slot_r        <= {SLOT_W{1'b0}};
            blank_cnt_r   <= {BL_W{1'b0}};
            fresh_r       <= 1'b1;
            frame_start_r <= 1'b0;
        end else begin
            fresh_r       <= 1'b0;
            frame_start_r <= fresh_r || (sb_s && (slot_r == SLOT_W'(CHANNELS - 1)));
            presc_r       <= tick_s ? {PS_W{1'b0}} : presc_r + PS_W'(1);
            if (tick_s) begin
                pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
            end
            if (pb_s) begin
                period_cnt_r <= sb_s ? {PC_W{1'b0}} : period_cnt_r + PC_W'(1);
            end
            if (sb_s) begin
                slot_r <= (slot_r == SLOT_W'(CHANNELS - 1)) ? {SLOT_W{1'b0}} : slot_r + SLOT_W'(1);
            end
            if (sb_s) begin
                blank_cnt_r <= BL_W'(BLANK_CYCLES);
            end else if (fresh_r) begin
                blank_cnt_r <= BL_W'(BLANK_FIRST);
            end else if (blank_cnt_r != {BL_W{1'b0}}) begin
                blank_cnt_r <= blank_cnt_r - BL_W'(1);
            end
        end
    end

    // Double buffer: a load on a period boundary bypasses pending straight to active.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_en_r   <= {CHANNELS{1'b0}};
            pend_duty_r <= {(CHANNELS*PWM_BITS){1'b0}};
            act_en_r    <= {CHANNELS{1'b0}};
            act_duty_r  <= {(CHANNELS*PWM_BITS){1'b0}};
        end else begin
            if (load) begin
                pend_en_r   <= en;
                pend_duty_r <= duty;
            end
            if (pb_s) begin
                act_en_r   <= load ? en : pend_en_r;
                act_duty_r <= load ? shaped_in_s : shaped_pend_s;
            end
        end
    end

    // Registered LED drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r <= {CHANNELS{1'b0}};
        end else begin
            out_r <= out_next_s;
        end
    end

    assign out         = out_r;
    assign slot        = slot_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_rgb_mux_pwm.sv
// Self-checking bench for rgb_mux_pwm: directed scenarios plus random loads/resets,
// checked against a time-index reference model (blanked and unblanked instances).
module tb_rgb_mux_pwm;

    localparam int CH  = 3;
    localparam int PW  = 4;
    localparam int PS  = 1;
    localparam int PPS = 2;
    localparam int BA  = 2;
    localparam int PER = PS * (1 << PW);
    localparam int SL  = PER * PPS;
    localparam int FR  = SL * CH;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [CH-1:0] en;
    logic [CH*PW-1:0] duty;
    logic [CH-1:0] out_a, out_b;
    logic [1:0]    slot_a, slot_b;
    logic          fs_a, fs_b;

    rgb_mux_pwm #(.CHANNELS(CH), .PWM_BITS(PW), .PRESCALE(PS), .PERIODS_PER_SLOT(PPS),
                  .BLANK_CYCLES(BA)) u_a (
        .clk(clk), .rst(rst), .en(en), .duty(duty), .load(load),
        .out(out_a), .slot(slot_a), .frame_start(fs_a));

    rgb_mux_pwm #(.CHANNELS(CH), .PWM_BITS(PW), .PRESCALE(PS), .PERIODS_PER_SLOT(PPS),
                  .BLANK_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .en(en), .duty(duty), .load(load),
        .out(out_b), .slot(slot_b), .frame_start(fs_b));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n = 0;
    int pend_d[CH], act_d[CH];
    bit pend_e[CH], act_e[CH];
    logic [CH-1:0] exp_a, exp_b;
    int exp_slot;
    bit exp_fs;
    int cnt_a[CH], cnt_b[CH], cnt_f;

    function automatic int gamma(input int d);
`ifdef RGB_MUX_PWM_GAMMA_EN
        return (d * d) >> PW;
`else
        return d;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d at n=%0d", tag, obs, expv, n);
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < CH; k++) begin
            cnt_a[k] = 0;
            cnt_b[k] = 0;
        end
        cnt_f = 0;
    endtask

    // One clock: advance the reference model across the edge, then compare.
    task automatic step();
        int pv, s, pw;
        @(posedge clk);
        if (rst) begin
            n = 0;
            for (int k = 0; k < CH; k++) begin
                pend_d[k] = 0; act_d[k] = 0; pend_e[k] = 0; act_e[k] = 0;
            end
            exp_a = '0; exp_b = '0; exp_slot = 0; exp_fs = 1'b0;
        end else begin
            pv = n;
            s  = (pv / SL) % CH;
            pw = (pv / PS) % (1 << PW);
            exp_a = '0;
            exp_b = '0;
            if (act_e[s] && act_d[s] > pw) begin
                exp_b[s] = 1'b1;
                if ((pv % SL) >= BA) exp_a[s] = 1'b1;
            end
            if ((pv % PER) == PER - 1) begin
                for (int k = 0; k < CH; k++) begin
                    act_d[k] = gamma(load ? int'(duty[k*PW +: PW]) : pend_d[k]);
                    act_e[k] = load ? en[k] : pend_e[k];
                end
            end
            if (load) begin
                for (int k = 0; k < CH; k++) begin
                    pend_d[k] = int'(duty[k*PW +: PW]);
                    pend_e[k] = en[k];
                end
            end
            n = pv + 1;
            exp_slot = (n / SL) % CH;
            exp_fs = (n == 1) || ((n % FR) == 0);
        end
        #1;
        chk("out_a", 32'(out_a), 32'(exp_a));
        chk("out_b", 32'(out_b), 32'(exp_b));
        chk("slot_a", 32'(slot_a), 32'(exp_slot));
        chk("slot_b", 32'(slot_b), 32'(exp_slot));
        chk("fs_a", 32'(fs_a), 32'(exp_fs));
        chk("fs_b", 32'(fs_b), 32'(exp_fs));
        chk("onehot_a", 32'($onehot0(out_a)), 32'd1);
        chk("onehot_b", 32'($onehot0(out_b)), 32'd1);
        for (int k = 0; k < CH; k++) begin
            cnt_a[k] += int'(out_a[k]);
            cnt_b[k] += int'(out_b[k]);
        end
        cnt_f += int'(fs_a);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic do_load(input logic [CH-1:0] e, input logic [CH*PW-1:0] d);
        en = e;
        duty = d;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; en = '0; duty = '0;
        clear_counts();
        run(2);
        chk("reset_out", 32'(out_a), 32'd0);
        chk("reset_slot", 32'(slot_a), 32'd0);
        rst = 1'b0;

        // Scenario 1/2: duties {8,4,0}, first frame and a half.
        do_load(3'b111, {4'd8, 4'd4, 4'd0});
        chk("fs_after_reset", 32'(fs_a), 32'd1);
        clear_counts();
        run(127);
        chk("slot1_ch1_high", 32'(cnt_a[1]), 32'd6);
        chk("slot2_ch2_high", 32'(cnt_a[2]), 32'd14);
        chk("ch0_dark", 32'(cnt_a[0]), 32'd0);
        chk("frame_pulses", 32'(cnt_f), 32'd1);

        // Scenario 3: mid-period load waits for pb; load on pb applies at once.
        clear_counts();
        run(5);
        do_load(3'b111, {4'd8, 4'd12, 4'd0});
        run(9);
        do_load(3'b111, {4'd8, 4'd7, 4'd0});
        run(16);
        chk("shadow_ch1_high", 32'(cnt_a[1]), 32'd9);

        // Scenario 4: near-full duty and disabled channel.
        do_load(3'b111, {4'd8, 4'd7, 4'd15});
        run(31);
        clear_counts();
        run(16);
        chk("duty15_noblank", 32'(cnt_b[0]), 32'd15);
        chk("duty15_blank", 32'(cnt_a[0]), 32'd13);
        do_load(3'b110, {4'd15, 4'd15, 4'd15});
        run(79);
        clear_counts();
        run(32);
        chk("en0_off_a", 32'(cnt_a[0]), 32'd0);
        chk("en0_off_b", 32'(cnt_b[0]), 32'd0);

        // Scenario 5: reset mid slot 2.
        run(40);
        chk("pre_rst_slot", 32'(slot_a), 32'd2);
        rst = 1'b1;
        step();
        chk("rst_out", 32'(out_a), 32'd0);
        chk("rst_slot", 32'(slot_a), 32'd0);
        rst = 1'b0;
        step();
        chk("rst_fs", 32'(fs_a), 32'd1);
        clear_counts();
        run(96);
        chk("post_rst_dark", 32'(cnt_a[0] + cnt_a[1] + cnt_a[2] + cnt_b[0] + cnt_b[1] + cnt_b[2]), 32'd0);
        chk("post_rst_frame", 32'(cnt_f), 32'd1);

        // Random loads and occasional resets against the model.
        for (int i = 0; i < 3000; i++) begin
            load = ($urandom_range(0, 7) == 0);
            en   = CH'($urandom);
            duty = (CH*PW)'($urandom);
            rst  = ($urandom_range(0, 699) == 0);
            step();
        end
        rst = 1'b0;
        load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
